// File: rtl/vga_scan_engine.sv
// VGA raster scan engine: counters, frame-latched object shadows and a one-stage colour/sync pipeline.
// Optional colour-bar test pattern is compiled in only when VGA_TEST_PATTERN_EN is defined.
module vga_scan_engine #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_POL   = 0,
   parameter int BRICK_COLS = 8,
   parameter int BRICK_ROWS = 3,
   parameter int BRICK_W    = 80,
   parameter int BRICK_H    = 20,
   parameter int BRICK_Y0   = 40,
   parameter int PADDLE_W   = 64,
   parameter int PADDLE_H   = 8,
   parameter int BALL_SIZE  = 8
) (
   input  logic                             i_dclk,
   input  logic                             i_clr_n,
   input  logic [10:0]                      i_paddle_h,
   input  logic [10:0]                      i_paddle_v,
   input  logic [10:0]                      i_ball_h,
   input  logic [10:0]                      i_ball_v,
   input  logic [BRICK_ROWS*BRICK_COLS-1:0] i_bricks,
   input  logic                             i_test_mode,
   output logic                             o_hsync,
   output logic                             o_vsync,
   output logic [2:0]                       o_red,
   output logic [2:0]                       o_green,
   output logic [1:0]                       o_blue,
   output logic [10:0]                      o_hcount,
   output logic [10:0]                      o_vcount,
   output logic                             o_frame_tick
);

   localparam int NBRICK  = BRICK_ROWS * BRICK_COLS;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic        SYNC_ACT   = (SYNC_POL != 0);
   localparam logic [7:0]  RGB_BALL   = 8'b111_111_11;
   localparam logic [7:0]  RGB_PADDLE = 8'b000_000_11;
   localparam logic [7:0]  RGB_BRICK  = 8'b111_000_00;

   logic [10:0]       r_hc;
   logic [10:0]       r_vc;
   logic [10:0]       r_paddleH;
   logic [10:0]       r_paddleV;
   logic [10:0]       r_ballH;
   logic [10:0]       r_ballV;
   logic [NBRICK-1:0] r_bricks;

   logic                  w_frameEnd;
   logic                  w_active;
   logic                  w_hsyncOn;
   logic                  w_vsyncOn;
   logic [11:0]           w_x;
   logic [11:0]           w_y;
   logic                  w_ballHit;
   logic                  w_paddleHit;
   logic [BRICK_COLS-1:0] w_colIn;
   logic [BRICK_ROWS-1:0] w_rowIn;
   logic                  w_brickHit;
   logic [7:0]            w_rgb;

   // Stage 0: free-running raster position; a reset anywhere restarts the frame at (0,0).
   always_ff @(posedge i_dclk) begin
      if (!i_clr_n) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (r_hc == H_LAST) begin
         r_hc <= '0;
         r_vc <= (r_vc == V_LAST) ? 11'd0 : r_vc + 11'd1;
      end else begin
         r_hc <= r_hc + 11'd1;
      end
   end

   assign w_frameEnd = (r_hc == H_LAST) && (r_vc == V_LAST);

   // Object positions are latched on the very last pixel so a whole frame renders from one snapshot.
   always_ff @(posedge i_dclk) begin
      if (!i_clr_n) begin
         r_paddleH <= '0;
         r_paddleV <= '0;
         r_ballH   <= '0;
         r_ballV   <= '0;
         r_bricks  <= '0;
      end else if (w_frameEnd) begin
         r_paddleH <= i_paddle_h;
         r_paddleV <= i_paddle_v;
         r_ballH   <= i_ball_h;
         r_ballV   <= i_ball_v;
         r_bricks  <= i_bricks;
      end
   end

   assign w_active  = (r_hc < 11'(H_ACTIVE)) && (r_vc < 11'(V_ACTIVE));
   assign w_hsyncOn = (r_hc >= HS_START) && (r_hc <= HS_END);
   assign w_vsyncOn = (r_vc >= VS_START) && (r_vc <= VS_END);

   // Widened by one bit so position plus size near 2047 cannot wrap into a false hit.
   assign w_x = {1'b0, r_hc};
   assign w_y = {1'b0, r_vc};

   assign w_ballHit = (w_x >= {1'b0, r_ballH}) && (w_x <= {1'b0, r_ballH} + 12'(BALL_SIZE - 1)) &&
                      (w_y >= {1'b0, r_ballV}) && (w_y <= {1'b0, r_ballV} + 12'(BALL_SIZE - 1));

   assign w_paddleHit = (w_x >= {1'b0, r_paddleH}) && (w_x <= {1'b0, r_paddleH} + 12'(PADDLE_W - 1)) &&
                        (w_y >= {1'b0, r_paddleV}) && (w_y <= {1'b0, r_paddleV} + 12'(PADDLE_H - 1));

   // Cell membership by constant compares; the upper bounds stop one short to leave a 1-pixel gap.
   always_comb begin
      w_colIn = '0;
      w_rowIn = '0;
      for (int c = 0; c < BRICK_COLS; c++) begin
         w_colIn[c] = (w_x >= 12'(c * BRICK_W)) && (w_x <= 12'((c + 1) * BRICK_W - 2));
      end
      for (int r = 0; r < BRICK_ROWS; r++) begin
         w_rowIn[r] = (w_y >= 12'(BRICK_Y0 + r * BRICK_H)) &&
                      (w_y <= 12'(BRICK_Y0 + (r + 1) * BRICK_H - 2));
      end
   end

   always_comb begin
      w_brickHit = 1'b0;
      for (int r = 0; r < BRICK_ROWS; r++) begin
         for (int c = 0; c < BRICK_COLS; c++) begin
            if (w_rowIn[r] && w_colIn[c] && r_bricks[r * BRICK_COLS + c]) begin
               w_brickHit = 1'b1;
            end
         end
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] w_bar;

   // Bar index is the count of boundaries passed, i.e. floor(hc*8/H_ACTIVE) without a divider.
   always_comb begin
      w_bar = '0;
      for (int b = 1; b < 8; b++) begin
         if ({r_hc, 3'b000} >= 14'(b * H_ACTIVE)) begin
            w_bar = 3'(b);
         end
      end
   end
`else
   logic w_unusedTestMode;
   assign w_unusedTestMode = i_test_mode;
`endif

   always_comb begin
      w_rgb = '0;
      if (w_active) begin
         if (w_ballHit) begin
            w_rgb = RGB_BALL;
         end else if (w_paddleHit) begin
            w_rgb = RGB_PADDLE;
         end else if (w_brickHit) begin
            w_rgb = RGB_BRICK;
         end
`ifdef VGA_TEST_PATTERN_EN
         if (i_test_mode) begin
            w_rgb = {{3{w_bar[2]}}, {3{w_bar[1]}}, {2{w_bar[0]}}};
         end
`endif
      end
   end

   // Stage 1: every visible output is registered together so they stay aligned to one pixel.
   always_ff @(posedge i_dclk) begin
      if (!i_clr_n) begin
         o_hsync      <= ~SYNC_ACT;
         o_vsync      <= ~SYNC_ACT;
         o_red        <= '0;
         o_green      <= '0;
         o_blue       <= '0;
         o_hcount     <= '0;
         o_vcount     <= '0;
         o_frame_tick <= 1'b0;
      end else begin
         o_hsync      <= w_hsyncOn ? SYNC_ACT : ~SYNC_ACT;
         o_vsync      <= w_vsyncOn ? SYNC_ACT : ~SYNC_ACT;
         o_red        <= w_rgb[7:5];
         o_green      <= w_rgb[4:2];
         o_blue       <= w_rgb[1:0];
         o_hcount     <= r_hc;
         o_vcount     <= r_vc;
         o_frame_tick <= (r_hc == 11'd0) && (r_vc == 11'd0);
      end
   end

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine using a reduced raster (144 x 128 total, 128 x 120 active)
// so several frames fit in a short run; brick cells are 16 wide to tile the narrower screen.
module tb_vga_scan_engine;

   logic        dclk = 1'b0;
   logic        clrN;
   logic [10:0] paddleH, paddleV, ballH, ballV;
   logic [23:0] bricks;
   logic        testMode;
   logic        hsync, vsync;
   logic [2:0]  red, green;
   logic [1:0]  blue;
   logic [10:0] hcount, vcount;
   logic        frameTick;

   int checks = 0;
   int errors = 0;
   int cycleCount = 0;
   int tFrame0 = 0;

   vga_scan_engine #(
      .H_ACTIVE(128), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(120), .V_FP(3), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(0), .BRICK_COLS(8), .BRICK_ROWS(3), .BRICK_W(16), .BRICK_H(20), .BRICK_Y0(40),
      .PADDLE_W(64), .PADDLE_H(8), .BALL_SIZE(8)
   ) dut (
      .i_dclk(dclk), .i_clr_n(clrN),
      .i_paddle_h(paddleH), .i_paddle_v(paddleV),
      .i_ball_h(ballH), .i_ball_v(ballV),
      .i_bricks(bricks), .i_test_mode(testMode),
      .o_hsync(hsync), .o_vsync(vsync),
      .o_red(red), .o_green(green), .o_blue(blue),
      .o_hcount(hcount), .o_vcount(vcount), .o_frame_tick(frameTick)
   );

   always #5 dclk = ~dclk;

   // Free-running edge count used to measure the frame period.
   always @(posedge dclk) cycleCount = cycleCount + 1;

   task automatic applyStimulus(input int bh, input int bv, input int ph, input int pv,
                                input logic [23:0] brk, input logic tm);
      ballH    = 11'(bh);
      ballV    = 11'(bv);
      paddleH  = 11'(ph);
      paddleV  = 11'(pv);
      bricks   = brk;
      testMode = tm;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance on falling edges until the outputs show the requested pixel; a frame is under 20000 cycles.
   task automatic waitPixel(input int x, input int y);
      for (int i = 0; i < 20000; i++) begin
         if (hcount == 11'(x) && vcount == 11'(y)) return;
         @(negedge dclk);
      end
      checks++;
      errors++;
      $display("[TB] FAIL wait_%0d_%0d observed timeout expected pixel reached", x, y);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] raster never reached the requested pixel");
   endtask

   task automatic checkPixel(input string tag, input int x, input int y, input int rgb);
      waitPixel(x, y);
      checkOutput(tag, int'({red, green, blue}), rgb);
   endtask

   initial begin
      clrN = 1'b0;
      applyStimulus(40, 100, 36, 96, 24'hFFFDFF, 1'b0);
      repeat (3) @(posedge dclk);
      @(negedge dclk);
      checkOutput("rst_hsync", int'(hsync), 1);
      checkOutput("rst_vsync", int'(vsync), 1);
      checkOutput("rst_rgb", int'({red, green, blue}), 0);
      checkOutput("rst_hcount", int'(hcount), 0);
      checkOutput("rst_vcount", int'(vcount), 0);
      checkOutput("rst_tick", int'(frameTick), 0);

      clrN = 1'b1;
      @(negedge dclk);
      checkOutput("first_hcount", int'(hcount), 0);
      checkOutput("first_vcount", int'(vcount), 0);
      checkOutput("first_tick", int'(frameTick), 1);
      checkOutput("f0_zero_shadow_ball", int'({red, green, blue}), 8'hFF);
      tFrame0 = cycleCount;
      @(negedge dclk);
      checkOutput("tick_single_cycle", int'(frameTick), 0);

      waitPixel(131, 0);
      checkOutput("hsync_before", int'(hsync), 1);
      waitPixel(132, 0);
      checkOutput("hsync_start", int'(hsync), 0);
      waitPixel(139, 0);
      checkOutput("hsync_last", int'(hsync), 0);
      waitPixel(140, 0);
      checkOutput("hsync_after", int'(hsync), 1);
      checkPixel("f0_no_brick_yet", 0, 40, 0);
      waitPixel(0, 122);
      checkOutput("vsync_before", int'(vsync), 1);
      waitPixel(0, 123);
      checkOutput("vsync_start", int'(vsync), 0);
      waitPixel(143, 124);
      checkOutput("vsync_last", int'(vsync), 0);
      waitPixel(0, 125);
      checkOutput("vsync_after", int'(vsync), 1);

      waitPixel(0, 0);
      checkOutput("f1_tick", int'(frameTick), 1);
      checkOutput("frame_period", cycleCount - tFrame0, 18432);
      checkPixel("above_grid", 0, 39, 0);
      checkPixel("brick_0", 0, 40, 8'hE0);
      checkPixel("brick_col_gap", 15, 40, 0);
      checkPixel("brick_1", 20, 45, 8'hE0);
      checkPixel("brick_row_gap", 16, 59, 0);
      checkPixel("brick_9_absent", 20, 65, 0);
      checkPixel("brick_10", 36, 65, 8'hE0);
      waitPixel(0, 70);
      applyStimulus(70, 100, 36, 96, 24'hFFFDFF, 1'b0);
      checkPixel("paddle_over_brick", 37, 97, 8'h03);
      checkPixel("ball_corner", 40, 100, 8'hFF);
      checkPixel("paddle_body", 60, 100, 8'h03);
      checkPixel("ball_move_deferred", 70, 100, 8'h03);
      checkPixel("ball_far_corner", 47, 107, 8'hFF);
      checkPixel("past_ball", 48, 108, 0);

      waitPixel(0, 0);
      checkOutput("f2_tick", int'(frameTick), 1);
      checkPixel("old_ball_gone", 40, 100, 8'h03);
      checkPixel("ball_moved", 70, 100, 8'hFF);
      testMode = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      checkPixel("bar4", 70, 101, 8'hE0);
      checkPixel("bar7", 112, 102, 8'hFF);
`else
      checkPixel("tm_ignored_ball", 70, 101, 8'hFF);
      checkPixel("tm_ignored_bg", 112, 102, 0);
`endif
      checkPixel("blank_in_tm", 130, 102, 0);
      waitPixel(132, 102);
      checkOutput("hsync_in_tm", int'(hsync), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
